// File: rtl/avl_sram_ctl_if.sv
// Avalon-MM command/response bundle between the AHB-to-Avalon bridge (master)
// and avl_sram_ctl (slave).
interface avl_sram_ctl_if;
  logic        chipselect;
  logic [17:2] address;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output chipselect, address, read_n, write_n, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  chipselect, address, read_n, write_n, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avl_sram_ctl.sv
// Avalon-MM slave driving a single-port synchronous SRAM with RD_LAT read latency.
// Optional byte parity on the SRAM data path is enabled by defining AVL_SRAM_PARITY_EN.
module avl_sram_ctl #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  avl_sram_ctl_if.slave     avl,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i,
  output logic              busy_o
`ifdef AVL_SRAM_PARITY_EN
  ,
  output logic [3:0]        sram_wpar_o,
  input  logic [3:0]        sram_rpar_i,
  output logic              par_err_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

  state_e              state_q, state_d;
  logic                sram_ce_q, sram_ce_d;
  logic                sram_we_q, sram_we_d;
  logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
  logic [31:0]         sram_wdata_q, sram_wdata_d;
  logic [31:0]         readdata_q, readdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                addr_oor;
  logic                cmd_rd;
  logic                cmd_wr;

  // Upper byte-address bits beyond the macro depth make the access out of range.
  generate
    if (ADDR_W < 16) begin : g_oor
      assign addr_oor = |avl.address[17:ADDR_W+2];
    end else begin : g_no_oor
      assign addr_oor = 1'b0;
    end
  endgenerate

  assign cmd_rd = ~avl.read_n &  avl.write_n;
  assign cmd_wr =  avl.read_n & ~avl.write_n;

`ifdef AVL_SRAM_PARITY_EN
  logic [3:0] wr_par;
  logic [3:0] rd_par;
  logic [3:0] sram_wpar_q, sram_wpar_d;
  logic       par_err_q, par_err_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_par
    assign wr_par[gi] = ^avl.writedata[gi*8 +: 8];
    assign rd_par[gi] = ^sram_rdata_i[gi*8 +: 8];
  end
`endif

  always_comb begin
    state_d      = state_q;
    sram_ce_d    = 1'b0;
    sram_we_d    = sram_we_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    readdata_d   = readdata_q;
    cnt_d        = cnt_q;
`ifdef AVL_SRAM_PARITY_EN
    sram_wpar_d  = sram_wpar_q;
    par_err_d    = par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (avl.chipselect) begin
          if (!(cmd_rd || cmd_wr)) begin
            state_d = S_DONE;
          end else if (addr_oor) begin
            // Out-of-range reads return zero; out-of-range writes vanish.
            if (cmd_rd) begin
              readdata_d = 32'h0;
            end
            state_d = S_DONE;
          end else begin
            sram_ce_d   = 1'b1;
            sram_we_d   = cmd_wr;
            sram_addr_d = avl.address[ADDR_W+1:2];
            if (cmd_wr) begin
              sram_wdata_d = avl.writedata;
`ifdef AVL_SRAM_PARITY_EN
              sram_wpar_d  = wr_par;
`endif
            end
            state_d = S_ACC;
          end
        end
      end

      S_ACC: begin
        if (sram_we_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = RD_LAT_C;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          readdata_d = sram_rdata_i;
`ifdef AVL_SRAM_PARITY_EN
          if (rd_par != sram_rpar_i) begin
            par_err_d = 1'b1;
          end
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      readdata_q   <= 32'h0;
      cnt_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      readdata_q   <= readdata_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef AVL_SRAM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_wpar_q <= 4'h0;
      par_err_q   <= 1'b0;
    end else begin
      sram_wpar_q <= sram_wpar_d;
      par_err_q   <= par_err_d;
    end
  end

  assign sram_wpar_o = sram_wpar_q;
  assign par_err_o   = par_err_q;
`endif

  // waitrequest is a pure function of state so the bridge never sees a comb path.
  assign avl.waitrequest = (state_q != S_DONE);
  assign avl.readdata    = readdata_q;
  assign busy_o          = (state_q != S_IDLE);
  assign sram_ce_o       = sram_ce_q;
  assign sram_we_o       = sram_we_q;
  assign sram_addr_o     = sram_addr_q;
  assign sram_wdata_o    = sram_wdata_q;

endmodule
